// File: rtl/serv_pkg.sv
// Shared widths, fetch FSM state encoding and small helpers for the SERV fetch path.
package serv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned WADR_W = 30;
    localparam int unsigned ST_W   = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = ST_W'(0),
        ST_FETCH = ST_W'(1),
        ST_PREF  = ST_W'(2),
        ST_DRAIN = ST_W'(3)
    } fetch_state_e;

    // Compressed or otherwise non-32-bit encodings are reported as illegal.
    function automatic logic is_illegal(input logic [XLEN-1:0] word);
        return word[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/serv_fetch_buf.sv
// One-entry prefetch buffer: holds a speculatively fetched word and its word address.
module serv_fetch_buf
    import serv_pkg::*;
(
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_wr,
    input  logic [WADR_W-1:0] i_wr_adr,
    input  logic [XLEN-1:0]   i_wr_dat,
    input  logic              i_clr,
    input  logic [WADR_W-1:0] i_cmp_adr,
    output logic              o_hit_c,
    output logic [XLEN-1:0]   o_dat
);

    logic              valid_q, valid_d;
    logic [WADR_W-1:0] adr_q, adr_d;
    logic [XLEN-1:0]   dat_q, dat_d;

    always_comb begin
        valid_d = valid_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        if (i_wr) begin
            valid_d = 1'b1;
            adr_d   = i_wr_adr;
            dat_d   = i_wr_dat;
        end else if (i_clr) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
        end else begin
            valid_q <= valid_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
        end
    end

    assign o_hit_c = valid_q && (adr_q == i_cmp_adr);
    assign o_dat   = dat_q;

endmodule

// File: rtl/serv_fetch.sv
// Instruction fetch unit: Wishbone instruction master with optional one-word
// sequential prefetch into a single-entry buffer.
module serv_fetch
    import serv_pkg::*;
#(
    parameter bit          PREFETCH = 1'b1,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_fetch_req,
    input  logic [WADR_W-1:0] i_fetch_adr,
    output logic              o_busy,
    output logic [XLEN-1:0]   o_ibus_adr,
    output logic              o_ibus_cyc,
    input  logic [XLEN-1:0]   i_ibus_rdt,
    input  logic              i_ibus_ack,
    output logic [XLEN-1:0]   o_rdt,
    output logic              o_rdt_en,
    output logic              o_illegal
);

    localparam logic [WADR_W-1:0] RESET_WADR = RESET_PC[XLEN-1:2];

    fetch_state_e      state_q, state_d;
    logic              boot_q, boot_d;
    logic [WADR_W-1:0] adr_q, adr_d;
    logic [WADR_W-1:0] pend_q, pend_d;
    logic              merge_q, merge_d;
    logic              cyc_q, cyc_d;
    logic              busy_q, busy_d;
    logic [XLEN-1:0]   rdt_q, rdt_d;
    logic              rdt_en_q, rdt_en_d;
    logic              illegal_q, illegal_d;

    logic              req, ack, adr_match;
    logic              deliver, start;
    logic              buf_wr, buf_clr, buf_hit_c;
    logic [XLEN-1:0]   buf_dat, dlv_dat;
    logic [WADR_W-1:0] dlv_adr, start_adr;

    serv_fetch_buf u_buf (
        .clk       (clk),
        .i_rst_n   (i_rst_n),
        .i_wr      (buf_wr),
        .i_wr_adr  (adr_q),
        .i_wr_dat  (i_ibus_rdt),
        .i_clr     (buf_clr),
        .i_cmp_adr (i_fetch_adr),
        .o_hit_c   (buf_hit_c),
        .o_dat     (buf_dat)
    );

    always_comb begin
        state_d   = state_q;
        boot_d    = boot_q;
        adr_d     = adr_q;
        pend_d    = pend_q;
        merge_d   = merge_q;
        cyc_d     = cyc_q;
        busy_d    = busy_q;
        rdt_d     = rdt_q;
        rdt_en_d  = 1'b0;
        illegal_d = 1'b0;
        buf_wr    = 1'b0;
        buf_clr   = 1'b0;
        deliver   = 1'b0;
        dlv_dat   = i_ibus_rdt;
        dlv_adr   = adr_q;
        start     = 1'b0;
        start_adr = i_fetch_adr;

        // A request in the delivery cycle is dropped so strobes never abut.
        req       = i_fetch_req && !busy_q && !rdt_en_q;
        ack       = i_ibus_ack && cyc_q;
        adr_match = (i_fetch_adr == adr_q);

        unique case (state_q)
            ST_IDLE: begin
                if (boot_q) begin
                    boot_d    = 1'b0;
                    start     = 1'b1;
                    start_adr = adr_q;
                end else if (req && buf_hit_c) begin
                    deliver = 1'b1;
                    dlv_dat = buf_dat;
                    dlv_adr = i_fetch_adr;
                    buf_clr = 1'b1;
                end else if (req) begin
                    start = 1'b1;
                end
            end
            ST_FETCH: begin
                if (ack) deliver = 1'b1;
            end
            ST_PREF: begin
                // Same-cycle ack and request: the acked word is buffered, then looked up.
                if (merge_q) begin
                    if (ack) deliver = 1'b1;
                end else if (req && ack) begin
                    if (adr_match) begin
                        deliver = 1'b1;
                        buf_clr = 1'b1;
                    end else begin
                        buf_wr = 1'b1;
                        start  = 1'b1;
                    end
                end else if (req) begin
                    busy_d = 1'b1;
                    if (adr_match) begin
                        merge_d = 1'b1;
                    end else begin
                        pend_d  = i_fetch_adr;
                        state_d = ST_DRAIN;
                    end
                end else if (ack) begin
                    buf_wr  = 1'b1;
                    state_d = ST_IDLE;
                    cyc_d   = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (ack) begin
                    start     = 1'b1;
                    start_adr = pend_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (deliver) begin
            rdt_d     = dlv_dat;
            rdt_en_d  = 1'b1;
            illegal_d = is_illegal(dlv_dat);
            busy_d    = 1'b0;
            merge_d   = 1'b0;
            if (PREFETCH) begin
                state_d = ST_PREF;
                cyc_d   = 1'b1;
                adr_d   = dlv_adr + WADR_W'(1);
            end else begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
            end
        end

        if (start) begin
            state_d = ST_FETCH;
            cyc_d   = 1'b1;
            busy_d  = 1'b1;
            merge_d = 1'b0;
            adr_d   = start_adr;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            boot_q    <= 1'b1;
            adr_q     <= RESET_WADR;
            pend_q    <= '0;
            merge_q   <= 1'b0;
            cyc_q     <= 1'b0;
            busy_q    <= 1'b0;
            rdt_q     <= '0;
            rdt_en_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            boot_q    <= boot_d;
            adr_q     <= adr_d;
            pend_q    <= pend_d;
            merge_q   <= merge_d;
            cyc_q     <= cyc_d;
            busy_q    <= busy_d;
            rdt_q     <= rdt_d;
            rdt_en_q  <= rdt_en_d;
            illegal_q <= illegal_d;
        end
    end

    assign o_busy     = busy_q;
    assign o_ibus_adr = {adr_q, 2'b00};
    assign o_ibus_cyc = cyc_q;
    assign o_rdt      = rdt_q;
    assign o_rdt_en   = rdt_en_q;
    assign o_illegal  = illegal_q;

endmodule

// File: tb/tb_serv_fetch.sv
// Directed plus randomized bench for serv_fetch against a word-addressed memory model.
module tb_serv_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic [29:0] fetch_adr;
    logic        busy;
    logic [31:0] ibus_adr;
    logic        ibus_cyc;
    logic [31:0] ibus_rdt;
    logic        ibus_ack;
    logic [31:0] rdt;
    logic        rdt_en;
    logic        illegal;

    int          total = 0;
    int          bad = 0;
    int          pcnt = 0;
    int          cnt = 0;
    int          wait_n = 2;
    logic        stray_ack = 1'b0;
    logic [31:0] salt;
    int          consec = 0;
    int          ill_stray = 0;
    logic        prev_en = 1'b0;

    logic [31:0] dq[$];
    logic        dil[$];
    int          dcyc[$];
    logic [31:0] aadr[$];
    int          acyc[$];

    serv_fetch dut (
        .clk         (clk),
        .i_rst_n     (rst_n),
        .i_fetch_req (fetch_req),
        .i_fetch_adr (fetch_adr),
        .o_busy      (busy),
        .o_ibus_adr  (ibus_adr),
        .o_ibus_cyc  (ibus_cyc),
        .i_ibus_rdt  (ibus_rdt),
        .i_ibus_ack  (ibus_ack),
        .o_rdt       (rdt),
        .o_rdt_en    (rdt_en),
        .o_illegal   (illegal)
    );

    always #5 clk = ~clk;

    // Instruction memory contents; two fixed words exercise the illegal flag.
    function automatic logic [31:0] mem(input logic [29:0] a);
        if (a == 30'h0C0) return 32'h0000_0000;
        if (a == 30'h0C1) return 32'h0000_0013;
        return {a[13:0], a[29:12]} ^ salt ^ (32'(a) * 32'h9E37_79B1);
    endfunction

    // Wishbone slave: ack after wait_n cycles of a held request.
    assign ibus_rdt = mem(ibus_adr[31:2]);
    assign ibus_ack = (ibus_cyc && (cnt >= wait_n)) || stray_ack;

    always @(posedge clk) begin
        pcnt <= pcnt + 1;
        cnt  <= (!ibus_cyc || ibus_ack) ? 0 : cnt + 1;
    end

    always @(negedge clk) begin
        if (rdt_en) begin
            dq.push_back(rdt);
            dil.push_back(illegal);
            dcyc.push_back(pcnt);
        end
        if (rdt_en && prev_en) consec <= consec + 1;
        if (illegal && !rdt_en) ill_stray <= ill_stray + 1;
        prev_en <= rdt_en;
        if (ibus_cyc && ibus_ack) begin
            aadr.push_back(ibus_adr);
            acyc.push_back(pcnt);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_dlv(input int n0, input string tag);
        for (int i = 0; i < 200 && dq.size() <= n0; i++) tick();
        chk({tag, "_cnt"}, 32'(dq.size()), 32'(n0 + 1));
    endtask

    // Issue one request and check the delivered word, illegal flag and optional latency.
    task automatic fetch(input logic [31:0] badr, input int gap, input int exp_lat, input string tag);
        int          n0;
        int          t0;
        logic [31:0] w;
        repeat (gap) tick();
        for (int i = 0; i < 200 && busy; i++) tick();
        n0 = dq.size();
        w = mem(badr[31:2]);
        fetch_req = 1'b1;
        fetch_adr = badr[31:2];
        t0 = pcnt;
        tick();
        fetch_req = 1'b0;
        wait_dlv(n0, tag);
        if (dq.size() > n0) begin
            chk({tag, "_rdt"}, dq[n0], w);
            chk({tag, "_ill"}, 32'(dil[n0]), 32'(w[1:0] != 2'b11));
            if (exp_lat > 0) chk({tag, "_lat"}, 32'(dcyc[n0] - t0), 32'(exp_lat));
        end
    endtask

    initial begin
        int          n0;
        int          na;
        logic [29:0] cur;

        salt      = $urandom;
        rst_n     = 1'b0;
        fetch_req = 1'b0;
        fetch_adr = '0;

        // Reset values
        #3;
        chk("rst_cyc", 32'(ibus_cyc), 32'(0));
        chk("rst_en", 32'(rdt_en), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_rdt", rdt, 32'h0);
        chk("rst_adr", ibus_adr, 32'h0);

        // Boot fetch of the reset PC with a 2-cycle ack, then prefetch of 4
        tick();
        rst_n = 1'b1;
        tick();
        chk("boot_cyc", 32'(ibus_cyc), 32'(1));
        chk("boot_adr", ibus_adr, 32'h0);
        chk("boot_busy", 32'(busy), 32'(1));
        wait_dlv(0, "boot");
        chk("boot_rdt", dq[0], mem(30'h0));
        chk("boot_pref_adr", ibus_adr, 32'h4);
        chk("boot_pref_cyc", 32'(ibus_cyc), 32'(1));
        repeat (6) tick();
        chk("boot_once", 32'(dq.size()), 32'(1));
        chk("boot_acks", 32'(aadr.size()), 32'(2));
        chk("boot_ack1", (aadr.size() > 1) ? aadr[1] : 32'hDEAD_BEEF, 32'h4);

        // Sequential stream with zero-wait ack: later requests hit the buffer
        wait_n = 0;
        na = aadr.size();
        fetch(32'h100, 2, 0, "seq0");
        fetch(32'h104, 2, 1, "seq1");
        fetch(32'h108, 1, 1, "seq2");
        fetch(32'h10C, 3, 1, "seq3");
        for (int k = 0; k < 4; k++)
            chk("seq_bus", (aadr.size() > na + k) ? aadr[na + k] : 32'hDEAD_BEEF, 32'h100 + 32'(4 * k));

        // Branch away while the prefetch of 0x104 is still waiting
        wait_n = 5;
        fetch(32'h100, 1, 0, "br0");
        na = aadr.size();
        n0 = dq.size();
        tick();
        fetch_req = 1'b1;
        fetch_adr = 30'h080;
        tick();
        fetch_req = 1'b0;
        chk("br_busy", 32'(busy), 32'(1));
        wait_dlv(n0, "br");
        chk("br_rdt", (dq.size() > n0) ? dq[n0] : 32'hDEAD_BEEF, mem(30'h080));
        chk("br_drain_adr", (aadr.size() > na) ? aadr[na] : 32'hDEAD_BEEF, 32'h104);
        chk("br_new_adr", (aadr.size() > na + 1) ? aadr[na + 1] : 32'hDEAD_BEEF, 32'h200);

        // Request merged into a slow prefetch; a request while busy is ignored
        fetch(32'h100, 1, 0, "mg0");
        na = aadr.size();
        n0 = dq.size();
        tick();
        fetch_req = 1'b1;
        fetch_adr = 30'h041;
        tick();
        chk("mg_busy", 32'(busy), 32'(1));
        fetch_adr = 30'h0FC;
        tick();
        fetch_req = 1'b0;
        wait_dlv(n0, "mg");
        chk("mg_rdt", (dq.size() > n0) ? dq[n0] : 32'hDEAD_BEEF, mem(30'h041));
        chk("mg_lat", 32'(dcyc[$] - acyc[$]), 32'(1));
        chk("mg_single", 32'(aadr.size() - na), 32'(1));
        chk("mg_adr", (aadr.size() > na) ? aadr[na] : 32'hDEAD_BEEF, 32'h104);

        // Request in the same cycle as the prefetch ack: hit, then miss
        wait_n = 1;
        fetch(32'h400, 2, 0, "sc0");
        fetch(32'h404, 1, 1, "sc_hit");
        fetch(32'h600, 1, 0, "sc_miss");

        // Prefetch address wraps from the top word to zero
        wait_n = 0;
        fetch(32'hFFFF_FFFC, 2, 0, "wrap");
        chk("wrap_adr", ibus_adr, 32'h0);
        fetch(32'h0, 2, 1, "wrap_hit");

        // Illegal flag on all-zero word, legal on ADDI encoding
        fetch(32'h300, 2, 0, "ill0");
        chk("ill0_flag", 32'(dil[$]), 32'(1));
        chk("ill0_word", dq[$], 32'h0);
        fetch(32'h304, 2, 1, "ill13");
        chk("ill13_flag", 32'(dil[$]), 32'(0));
        chk("ill13_word", dq[$], 32'h13);

        // Randomized mix of sequential and jump requests with varying latency
        cur = 30'h40;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 2) != 0) cur = cur + 30'd1;
            else cur = 30'h40 + 30'($urandom_range(0, 63));
            wait_n = int'($urandom_range(0, 3));
            fetch({cur, 2'b00}, int'($urandom_range(1, 3)), 0, "rnd");
        end

        // Reset asserted during a demand fetch
        wait_n = 0;
        repeat (4) tick();
        wait_n = 10;
        fetch_req = 1'b1;
        fetch_adr = 30'h1C0;
        tick();
        fetch_req = 1'b0;
        tick();
        chk("rf_cyc", 32'(ibus_cyc), 32'(1));
        chk("rf_adr", ibus_adr, 32'h700);
        n0 = dq.size();
        #2;
        rst_n = 1'b0;
        stray_ack = 1'b1;
        #1;
        chk("rf_async_cyc", 32'(ibus_cyc), 32'(0));
        chk("rf_async_busy", 32'(busy), 32'(0));
        chk("rf_async_adr", ibus_adr, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        stray_ack = 1'b0;
        wait_n = 1;
        tick();
        chk("rf_boot_cyc", 32'(ibus_cyc), 32'(1));
        chk("rf_boot_adr", ibus_adr, 32'h0);
        wait_dlv(n0, "rf");
        chk("rf_rdt", (dq.size() > n0) ? dq[n0] : 32'hDEAD_BEEF, mem(30'h0));
        repeat (4) tick();
        chk("rf_once", 32'(dq.size()), 32'(n0 + 1));

        chk("no_consec_en", 32'(consec), 32'(0));
        chk("ill_qualified", 32'(ill_stray), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
